// File: rtl/msrv32_decode_stage.sv
// RV32I decode stage: combinational decoder feeding a registered output slot
// backed by a one-entry skid register, with trap flush and illegal-instruction counter.
module msrv32_decode_stage #(
    parameter int unsigned ILLEGAL_CNT_W  = 8,
    parameter bit          ENABLE_CSR     = 1'b1,
    parameter bit          CHECK_MISALIGN = 1'b1
) (
    input  logic                     ms_riscv32_mp_clk_in,
    input  logic                     ms_riscv32_mp_rst_in,
    input  logic [31:0]              instr_in,
    input  logic [1:0]               iadder_out_1_to_0_in,
    input  logic                     instr_valid_in,
    output logic                     instr_ready_out,
    input  logic                     trap_taken_in,
    output logic                     dec_valid_out,
    input  logic                     dec_ready_in,
    output logic [2:0]               wb_mux_sel_out,
    output logic [2:0]               imm_type_out,
    output logic [2:0]               csr_op_out,
    output logic [3:0]               alu_opcode_out,
    output logic [1:0]               load_size_out,
    output logic                     load_unsigned_out,
    output logic                     alu_src_out,
    output logic                     iadder_src_out,
    output logic                     mem_wr_req_out,
    output logic                     csr_wr_en_out,
    output logic                     rf_wr_en_out,
    output logic                     illegal_instr_out,
    output logic                     misaligned_load_out,
    output logic                     misaligned_store_out,
    output logic [ILLEGAL_CNT_W-1:0] illegal_count_out
);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef struct packed {
        logic [2:0] wb_mux_sel;
        logic [2:0] imm_type;
        logic [2:0] csr_op;
        logic [3:0] alu_opcode;
        logic [1:0] load_size;
        logic       load_unsigned;
        logic       alu_src;
        logic       iadder_src;
        logic       mem_wr_req;
        logic       csr_wr_en;
        logic       rf_wr_en;
        logic       illegal;
        logic       mis_ld;
        logic       mis_st;
    } dec_t;

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_bits;

    assign opc         = instr_in[6:2];
    assign f3          = instr_in[14:12];
    assign f7          = instr_in[31:25];
    assign unused_bits = ^{instr_in[24:15], instr_in[11:7]};

    // Size encoding follows funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic misal(input logic [1:0] sz, input logic [1:0] a);
        return ((sz == 2'b10) && (a != 2'b00)) || ((sz == 2'b01) && a[0]);
    endfunction

    dec_t dec;
    logic ill, mld, mst;

    always_comb begin
        dec = '0;
        ill = 1'b0;
        mld = 1'b0;
        mst = 1'b0;
        if (instr_in[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opc)
                OPC_OP: begin
                    dec.alu_src    = 1'b1;
                    dec.rf_wr_en   = 1'b1;
                    dec.alu_opcode = {f7[5], f3};
                    if (!((f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))))
                        ill = 1'b1;
                end
                OPC_OP_IMM: begin
                    dec.imm_type   = 3'b001;
                    dec.rf_wr_en   = 1'b1;
                    dec.alu_opcode = {f7[5] & (f3 == 3'b101), f3};
                    if ((f3 == 3'b001) && (f7 != 7'b0000000))
                        ill = 1'b1;
                    if ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000))
                        ill = 1'b1;
                end
                OPC_LOAD: begin
                    dec.wb_mux_sel    = 3'b001;
                    dec.imm_type      = 3'b001;
                    dec.iadder_src    = 1'b1;
                    dec.rf_wr_en      = 1'b1;
                    dec.load_size     = f3[1:0];
                    dec.load_unsigned = f3[2];
                    if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111))
                        ill = 1'b1;
                    mld = misal(f3[1:0], iadder_out_1_to_0_in);
                end
                OPC_STORE: begin
                    dec.imm_type   = 3'b010;
                    dec.iadder_src = 1'b1;
                    dec.mem_wr_req = 1'b1;
                    if (f3 > 3'b010)
                        ill = 1'b1;
                    mst = misal(f3[1:0], iadder_out_1_to_0_in);
                end
                OPC_BRANCH: begin
                    dec.imm_type = 3'b011;
                    if ((f3 == 3'b010) || (f3 == 3'b011))
                        ill = 1'b1;
                end
                OPC_JALR: begin
                    dec.wb_mux_sel = 3'b011;
                    dec.imm_type   = 3'b001;
                    dec.iadder_src = 1'b1;
                    dec.rf_wr_en   = 1'b1;
                    if (f3 != 3'b000)
                        ill = 1'b1;
                end
                OPC_JAL: begin
                    dec.wb_mux_sel = 3'b011;
                    dec.imm_type   = 3'b101;
                    dec.rf_wr_en   = 1'b1;
                end
                OPC_LUI: begin
                    dec.wb_mux_sel = 3'b010;
                    dec.imm_type   = 3'b100;
                    dec.rf_wr_en   = 1'b1;
                end
                OPC_AUIPC: begin
                    dec.wb_mux_sel = 3'b101;
                    dec.imm_type   = 3'b100;
                    dec.rf_wr_en   = 1'b1;
                end
                OPC_MISC_MEM: begin
                end
                OPC_SYSTEM: begin
                    // funct3 000 (ECALL/EBREAK/MRET) is legal but writes nothing.
                    if (f3 == 3'b100) begin
                        ill = 1'b1;
                    end else if (f3 != 3'b000) begin
                        if (!ENABLE_CSR) begin
                            ill = 1'b1;
                        end else begin
                            dec.wb_mux_sel = 3'b100;
                            dec.imm_type   = 3'b110;
                            dec.csr_op     = f3;
                            dec.rf_wr_en   = 1'b1;
                            dec.csr_wr_en  = 1'b1;
                        end
                    end
                end
                default: ill = 1'b1;
            endcase
        end
        if (!CHECK_MISALIGN) begin
            mld = 1'b0;
            mst = 1'b0;
        end
        dec.illegal = ill;
        dec.mis_ld  = mld;
        dec.mis_st  = mst;
        if (ill || mld || mst) begin
            dec.rf_wr_en   = 1'b0;
            dec.mem_wr_req = 1'b0;
            dec.csr_wr_en  = 1'b0;
        end
    end

    dec_t                     or_q, or_d, sk_q, sk_d;
    logic                     or_v_q, or_v_d, sk_v_q, sk_v_d, rdy_q, rdy_d;
    logic [ILLEGAL_CNT_W-1:0] cnt_q, cnt_d;
    logic                     accept, or_load, deliver;

    assign accept  = instr_valid_in & rdy_q;
    assign or_load = ~or_v_q | dec_ready_in;
    assign deliver = or_v_q & dec_ready_in & ~trap_taken_in;

    // SK only fills while OR is stalled, so ready is simply "SK empty".
    always_comb begin
        or_d   = or_q;
        sk_d   = sk_q;
        or_v_d = or_v_q;
        sk_v_d = sk_v_q;
        if (trap_taken_in) begin
            or_v_d = 1'b0;
            sk_v_d = 1'b0;
        end else if (or_load) begin
            if (sk_v_q) begin
                or_d   = sk_q;
                or_v_d = 1'b1;
                sk_v_d = 1'b0;
            end else begin
                or_v_d = accept;
                if (accept)
                    or_d = dec;
            end
        end else if (accept) begin
            sk_d   = dec;
            sk_v_d = 1'b1;
        end
        rdy_d = ~sk_v_d;
        cnt_d = cnt_q;
        if (deliver && or_q.illegal && (cnt_q != '1))
            cnt_d = cnt_q + ILLEGAL_CNT_W'(1);
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            or_q   <= '0;
            sk_q   <= '0;
            or_v_q <= 1'b0;
            sk_v_q <= 1'b0;
            rdy_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            or_q   <= or_d;
            sk_q   <= sk_d;
            or_v_q <= or_v_d;
            sk_v_q <= sk_v_d;
            rdy_q  <= rdy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign instr_ready_out      = rdy_q;
    assign dec_valid_out        = or_v_q;
    assign wb_mux_sel_out       = or_q.wb_mux_sel;
    assign imm_type_out         = or_q.imm_type;
    assign csr_op_out           = or_q.csr_op;
    assign alu_opcode_out       = or_q.alu_opcode;
    assign load_size_out        = or_q.load_size;
    assign load_unsigned_out    = or_q.load_unsigned;
    assign alu_src_out          = or_q.alu_src;
    assign iadder_src_out       = or_q.iadder_src;
    assign mem_wr_req_out       = or_q.mem_wr_req;
    assign csr_wr_en_out        = or_q.csr_wr_en;
    assign rf_wr_en_out         = or_q.rf_wr_en;
    assign illegal_instr_out    = or_q.illegal;
    assign misaligned_load_out  = or_q.mis_ld;
    assign misaligned_store_out = or_q.mis_st;
    assign illegal_count_out    = cnt_q;

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// Directed bench: default-parameter DUT (a) alongside a DUT (b) with a 2-bit
// counter, CSR support off and misalignment checking off, sharing one stimulus.
module tb_msrv32_decode_stage;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_SUB   = 32'h403100B3;
    localparam logic [31:0] I_LW    = 32'h0000A083;
    localparam logic [31:0] I_SH    = 32'h00209023;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_CSRRW = 32'h30029073;
    localparam logic [31:0] I_BAD0  = 32'h00000000;
    localparam logic [31:0] I_BAD1  = 32'h0000707F;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] instr = '0;
    logic [1:0]  addr = '0;
    logic        vin = 1'b0, trap = 1'b0, dready = 1'b0;

    logic       rdy_a, vld_a, lu_a, asrc_a, isrc_a, mw_a, cw_a, rf_a, ill_a, ml_a, ms_a;
    logic [2:0] wb_a, imm_a, csr_a;
    logic [3:0] alu_a;
    logic [1:0] ls_a;
    logic [7:0] cnt_a;
    logic       rdy_b, vld_b, lu_b, asrc_b, isrc_b, mw_b, cw_b, rf_b, ill_b, ml_b, ms_b;
    logic [2:0] wb_b, imm_b, csr_b;
    logic [3:0] alu_b;
    logic [1:0] ls_b;
    logic [1:0] cnt_b;

    logic [23:0] bun_a;
    assign bun_a = {wb_a, imm_a, csr_a, alu_a, ls_a, lu_a, asrc_a, isrc_a, mw_a, cw_a, rf_a, ill_a, ml_a, ms_a};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    msrv32_decode_stage dut_a (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .instr_in(instr), .iadder_out_1_to_0_in(addr),
        .instr_valid_in(vin), .instr_ready_out(rdy_a), .trap_taken_in(trap),
        .dec_valid_out(vld_a), .dec_ready_in(dready),
        .wb_mux_sel_out(wb_a), .imm_type_out(imm_a), .csr_op_out(csr_a),
        .alu_opcode_out(alu_a), .load_size_out(ls_a), .load_unsigned_out(lu_a),
        .alu_src_out(asrc_a), .iadder_src_out(isrc_a), .mem_wr_req_out(mw_a),
        .csr_wr_en_out(cw_a), .rf_wr_en_out(rf_a), .illegal_instr_out(ill_a),
        .misaligned_load_out(ml_a), .misaligned_store_out(ms_a),
        .illegal_count_out(cnt_a)
    );

    msrv32_decode_stage #(.ILLEGAL_CNT_W(2), .ENABLE_CSR(1'b0), .CHECK_MISALIGN(1'b0)) dut_b (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .instr_in(instr), .iadder_out_1_to_0_in(addr),
        .instr_valid_in(vin), .instr_ready_out(rdy_b), .trap_taken_in(trap),
        .dec_valid_out(vld_b), .dec_ready_in(dready),
        .wb_mux_sel_out(wb_b), .imm_type_out(imm_b), .csr_op_out(csr_b),
        .alu_opcode_out(alu_b), .load_size_out(ls_b), .load_unsigned_out(lu_b),
        .alu_src_out(asrc_b), .iadder_src_out(isrc_b), .mem_wr_req_out(mw_b),
        .csr_wr_en_out(cw_b), .rf_wr_en_out(rf_b), .illegal_instr_out(ill_b),
        .misaligned_load_out(ml_b), .misaligned_store_out(ms_b),
        .illegal_count_out(cnt_b)
    );

    function automatic logic [23:0] mk(input logic [2:0] wb, input logic [2:0] imm,
                                       input logic [2:0] csr, input logic [3:0] alu,
                                       input logic [1:0] ls, input logic lu, input logic asrc,
                                       input logic isrc, input logic mw, input logic cw,
                                       input logic rf, input logic ill, input logic ml,
                                       input logic ms);
        return {wb, imm, csr, alu, ls, lu, asrc, isrc, mw, cw, rf, ill, ml, ms};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vin = 1'b0; trap = 1'b0; dready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vld_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy_a); end
        checks++; if (bun_a !== 24'h0) begin errors++; $display("FAIL reset_bundle: got %h want 000000", bun_a); end
        checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
    endtask

    task automatic test_alu();
        logic [23:0] e;
        dready = 1'b1; vin = 1'b1; addr = 2'b00; instr = I_ADD;
        tick();
        e = mk(3'd0, 3'd0, 3'd0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (vld_a !== 1'b1 || bun_a !== e) begin errors++; $display("FAIL add: got v=%b %h want v=1 %h", vld_a, bun_a, e); end
        instr = I_SUB;
        tick();
        e = mk(3'd0, 3'd0, 3'd0, 4'h8, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (vld_a !== 1'b1 || bun_a !== e) begin errors++; $display("FAIL sub: got v=%b %h want v=1 %h", vld_a, bun_a, e); end
        vin = 1'b0;
        tick();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL alu_drain: got v=%b want 0", vld_a); end
    endtask

    task automatic test_misalign();
        logic [23:0] e;
        vin = 1'b1; instr = I_LW; addr = 2'b10;
        tick();
        e = mk(3'd1, 3'd1, 3'd0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bun_a !== e) begin errors++; $display("FAIL lw_mis: got %h want %h", bun_a, e); end
        checks++; if (ml_b !== 1'b0 || rf_b !== 1'b1) begin errors++; $display("FAIL lw_nocheck: got ml=%b rf=%b want ml=0 rf=1", ml_b, rf_b); end
        addr = 2'b00;
        tick();
        e = mk(3'd1, 3'd1, 3'd0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bun_a !== e) begin errors++; $display("FAIL lw_ok: got %h want %h", bun_a, e); end
        instr = I_SH; addr = 2'b01;
        tick();
        e = mk(3'd0, 3'd2, 3'd0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bun_a !== e) begin errors++; $display("FAIL sh_mis: got %h want %h", bun_a, e); end
        addr = 2'b10;
        tick();
        e = mk(3'd0, 3'd2, 3'd0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bun_a !== e) begin errors++; $display("FAIL sh_ok: got %h want %h", bun_a, e); end
        instr = I_FENCE; addr = 2'b00;
        tick();
        checks++; if (vld_a !== 1'b1 || bun_a !== 24'h0) begin errors++; $display("FAIL fence: got v=%b %h want v=1 000000", vld_a, bun_a); end
        vin = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        vin = 1'b1; instr = I_BAD0;
        tick();
        checks++; if (bun_a !== 24'h000004 || cnt_a !== 8'd0) begin errors++; $display("FAIL ill_zero: got %h cnt=%0d want 000004 cnt=0", bun_a, cnt_a); end
        instr = I_BAD1;
        tick();
        checks++; if (bun_a !== 24'h000004 || cnt_a !== 8'd1) begin errors++; $display("FAIL ill_ones: got %h cnt=%0d want 000004 cnt=1", bun_a, cnt_a); end
        vin = 1'b0;
        tick();
        checks++; if (cnt_a !== 8'd2) begin errors++; $display("FAIL ill_count: got %0d want 2", cnt_a); end
    endtask

    task automatic test_saturate();
        vin = 1'b1; instr = I_BAD0;
        repeat (6) tick();
        vin = 1'b0;
        tick();
        checks++; if (cnt_a !== 8'd8) begin errors++; $display("FAIL count_a: got %0d want 8", cnt_a); end
        checks++; if (cnt_b !== 2'd3) begin errors++; $display("FAIL count_sat: got %0d want 3", cnt_b); end
    endtask

    task automatic test_csr();
        logic [23:0] e;
        vin = 1'b1; instr = I_CSRRW;
        tick();
        vin = 1'b0;
        e = mk(3'd4, 3'd6, 3'd1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bun_a !== e) begin errors++; $display("FAIL csrrw: got %h want %h", bun_a, e); end
        checks++; if (ill_b !== 1'b1 || cw_b !== 1'b0 || rf_b !== 1'b0) begin errors++; $display("FAIL csr_off: got ill=%b cw=%b rf=%b want 1 0 0", ill_b, cw_b, rf_b); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [23:0] e_add, e_sub, e_lw;
        e_add = mk(3'd0, 3'd0, 3'd0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e_sub = mk(3'd0, 3'd0, 3'd0, 4'h8, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e_lw  = mk(3'd1, 3'd1, 3'd0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        dready = 1'b0; vin = 1'b1; addr = 2'b00; instr = I_ADD;
        tick();
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", rdy_a); end
        instr = I_SUB;
        tick();
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL bp_ready2: got %b want 0", rdy_a); end
        instr = I_LW;
        tick();
        checks++; if (rdy_a !== 1'b0 || vld_a !== 1'b1 || bun_a !== e_add) begin errors++; $display("FAIL bp_hold: got r=%b v=%b %h want r=0 v=1 %h", rdy_a, vld_a, bun_a, e_add); end
        dready = 1'b1;
        tick();
        checks++; if (vld_a !== 1'b1 || bun_a !== e_sub || rdy_a !== 1'b1) begin errors++; $display("FAIL bp_second: got r=%b v=%b %h want r=1 v=1 %h", rdy_a, vld_a, bun_a, e_sub); end
        tick();
        vin = 1'b0;
        checks++; if (vld_a !== 1'b1 || bun_a !== e_lw) begin errors++; $display("FAIL bp_third: got v=%b %h want v=1 %h", vld_a, bun_a, e_lw); end
        tick();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL bp_drain: got v=%b want 0", vld_a); end
    endtask

    task automatic test_flush();
        dready = 1'b0; vin = 1'b1; instr = I_ADD;
        tick();
        instr = I_SUB;
        tick();
        checks++; if (rdy_a !== 1'b0 || vld_a !== 1'b1) begin errors++; $display("FAIL flush_pre: got r=%b v=%b want r=0 v=1", rdy_a, vld_a); end
        trap = 1'b1; instr = I_LW;
        tick();
        trap = 1'b0; vin = 1'b0;
        checks++; if (vld_a !== 1'b0 || rdy_a !== 1'b1) begin errors++; $display("FAIL flush: got v=%b r=%b want v=0 r=1", vld_a, rdy_a); end
        dready = 1'b1;
        tick();
        checks++; if (vld_a !== 1'b0 || cnt_a !== 8'd8) begin errors++; $display("FAIL flush_after: got v=%b cnt=%0d want v=0 cnt=8", vld_a, cnt_a); end
    endtask

    task automatic test_reset_mid();
        dready = 1'b0; vin = 1'b1; instr = I_ADD;
        tick();
        instr = I_SUB;
        tick();
        rst = 1'b1; vin = 1'b0;
        tick();
        rst = 1'b0; dready = 1'b1;
        checks++; if (vld_a !== 1'b0 || rdy_a !== 1'b1 || cnt_a !== 8'd0 || bun_a !== 24'h0) begin errors++; $display("FAIL reset_mid: got v=%b r=%b cnt=%0d %h want v=0 r=1 cnt=0 000000", vld_a, rdy_a, cnt_a, bun_a); end
        tick();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_mid_drain: got v=%b want 0", vld_a); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_misalign();
        test_illegal();
        test_saturate();
        test_csr();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msrv32_decode_stage.md
Name: msrv32_decode_stage

Overview:
- Registered RV32I decode stage with a valid/ready handshake on both sides and a two-entry skid buffer, so full throughput is kept under downstream backpressure.
- Generalises the combinational decoder with parametrised CSR support, optional misalignment checking, trap flush and a saturating illegal-instruction counter.
- Sits between instruction fetch and the register-file/execute stage.

Parameters:
- ILLEGAL_CNT_W, 8: width of the saturating illegal-instruction counter.
- ENABLE_CSR, 1: if 0, every SYSTEM instruction with funct3!=000 decodes as illegal.
- CHECK_MISALIGN, 1: if 0, misaligned_load_out and misaligned_store_out are forced to 0.

Ports:
- ms_riscv32_mp_clk_in  in  1  clock, rising edge.
- ms_riscv32_mp_rst_in  in  1  reset, synchronous, active-high.
- instr_in  in  32  instruction word.
- iadder_out_1_to_0_in  in  2  effective-address bits [1:0], qualified by instr_valid_in.
- instr_valid_in  in  1  upstream valid.
- instr_ready_out  out  1  upstream ready.
- trap_taken_in  in  1  flush request.
- dec_valid_out  out  1  decoded bundle valid.
- dec_ready_in  in  1  downstream ready.
- wb_mux_sel_out  out  3  writeback select: 000 ALU, 001 LOAD, 010 LUI immediate, 011 PC+4, 100 CSR, 101 AUIPC/iadder.
- imm_type_out  out  3  immediate type: 000 none/R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 CSR zimm.
- csr_op_out  out  3  funct3 for CSR instructions, else 000.
- alu_opcode_out  out  4  {alt, funct3}.
- load_size_out  out  2  funct3[1:0] for loads, else 00.
- load_unsigned_out  out  1  funct3[2] for loads, else 0.
- alu_src_out  out  1  1 = rs2, 0 = immediate.
- iadder_src_out  out  1  1 = rs1 base (JALR/LOAD/STORE), 0 = PC.
- mem_wr_req_out, csr_wr_en_out, rf_wr_en_out  out  1 each  write requests.
- illegal_instr_out, misaligned_load_out, misaligned_store_out  out  1 each  exception flags.
- illegal_count_out  out  ILLEGAL_CNT_W  saturating count of illegal instructions delivered.

Behaviour:

Decode (combinational, on the input side):
- opcode[1:0]!=11 or unknown opcode[6:2] -> illegal.
- OP:
  - funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise illegal.
  - alu_opcode = {funct7[5], funct3}; alu_src = 1.
- OP_IMM:
  - alu_opcode = {funct7[5] & (funct3==101), funct3}.
  - Shifts (funct3 001/101) require funct7 to be 0000000 (or 0100000 for 101); otherwise illegal.
- All other opcodes: alu_opcode = 0000.
- LOAD: funct3 011/110/111 illegal.
- STORE: funct3 > 010 illegal.
- BRANCH: funct3 010/011 illegal.
- JALR: funct3 != 000 illegal.
- SYSTEM: funct3 100 illegal. funct3 000 (ECALL/EBREAK/MRET) is legal with all write enables 0.
- rf_wr_en = OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, CSR.
- mem_wr_req = STORE.
- csr_wr_en = SYSTEM & funct3!=000.
- Misaligned:
  - Word access requires addr[1:0]=00; halfword access requires addr[0]=0; byte access is never misaligned.
  - Applies to LOAD (load flag) and STORE (store flag).
- Gating: illegal, or the matching misaligned flag, forces rf_wr_en, mem_wr_req and csr_wr_en to 0.
- MISC_MEM (FENCE): legal no-op.

Handshake and buffering:
- Accept when instr_valid_in & instr_ready_out.
- Output register (OR) and skid register (SK) each have their own valid bit.
- instr_ready_out = ~SK.valid (from a register; 1 during and after reset).
- OR loads when it is empty or dec_ready_in=1. Its source is SK if SK is valid, otherwise the newly decoded input.
- An accepted input while OR is held (valid, dec_ready_in=0) goes to SK.
- Latency: 1 cycle from accept to dec_valid_out with OR empty.
- Throughput: 1 instruction per cycle.
- Order is always preserved.
- The output bundle is stable while dec_valid_out=1 and dec_ready_in=0.

Flush:
- trap_taken_in=1 clears OR.valid and SK.valid at the next edge.
- Input offered in the same cycle is dropped.
- Flush has priority over simultaneous accept and output transfer.

Counter:
- Increments on dec_valid_out & dec_ready_in & illegal_instr_out.
- Saturates at all-ones.
- Not cleared by flush.

Reset:
- Synchronous. All outputs 0 except instr_ready_out = 1.
- Both valid bits and the counter are cleared.
- Reset mid-transfer discards all buffered instructions.

Test Plan:
- ADD 0x003100B3, then SUB 0x403100B3, dec_ready_in=1 -> one cycle later alu_opcode 0000, then 1000; wb_mux_sel 000; rf_wr_en 1; alu_src 1; illegal 0.
- LW 0x0000A083 with iadder_out_1_to_0_in=10 -> misaligned_load 1, rf_wr_en 0, load_size 10. Same with 00 -> misaligned_load 0, rf_wr_en 1.
- Instructions 0x00000000 and 0x0000707F delivered -> illegal_instr_out 1 for each, illegal_count_out 0 -> 2. With ILLEGAL_CNT_W=2 and 5 illegal instructions -> count stays at 3.
- Three back-to-back ADDs with dec_ready_in=0 -> instr_ready_out drops after 2 accepts. Release dec_ready_in -> instructions delivered in order on consecutive cycles, no loss or duplication.
- ENABLE_CSR=0, CSRRW 0x30029073 -> illegal 1, csr_wr_en 0. ENABLE_CSR=1 -> csr_wr_en 1, csr_op 001, wb_mux_sel 100, imm_type 110.
- OR and SK both full, assert trap_taken_in with instr_valid_in=1 -> next cycle dec_valid_out 0, instr_ready_out 1, nothing delivered.
